// File: rtl/order_ingress_arbiter_if.sv
// Order ingress arbiter bus: UDP/Bot FIFO read ports,
// matching-engine issue port and per-source counters.
interface order_ingress_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             udp_empty;
    logic [31:0]      udp_dout;
    logic             udp_rd_en;
    logic             bot_empty;
    logic [31:0]      bot_dout;
    logic             bot_rd_en;
    logic             engine_busy;
    logic             ord_valid;
    logic [31:0]      ord_data;
    logic             ord_src_bot;
    logic             udp_fifo_has_data;
    logic [CNT_W-1:0] udp_cnt;
    logic [CNT_W-1:0] bot_cnt;

    modport master (
        input  udp_empty, udp_dout,
        input  bot_empty, bot_dout,
        input  engine_busy,
        output udp_rd_en, bot_rd_en,
        output ord_valid, ord_data, ord_src_bot,
        output udp_fifo_has_data,
        output udp_cnt, bot_cnt
    );

    modport slave (
        output udp_empty, udp_dout,
        output bot_empty, bot_dout,
        output engine_busy,
        input  udp_rd_en, bot_rd_en,
        input  ord_valid, ord_data, ord_src_bot,
        input  udp_fifo_has_data,
        input  udp_cnt, bot_cnt
    );
endinterface

// File: rtl/order_ingress_arbiter.sv
// Strict-priority (UDP over Bot) order ingress arbiter.
// Optional ARB_TAG_FORCE_EN: force ord_data[14] to the true source.
module order_ingress_arbiter #(
    parameter int CNT_W = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    order_ingress_arbiter_if.master arb
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic             run_q;
    logic             src_bot_q, src_bot_d;
    logic             udp_rd_q, udp_rd_d;
    logic             bot_rd_q, bot_rd_d;
    logic             vld_q, vld_d;
    logic [31:0]      data_q, data_d;
    logic             obot_q, obot_d;
    logic [CNT_W-1:0] ucnt_q, ucnt_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [31:0]      cap_word;
    logic             any_req;

    assign any_req = !arb.udp_empty || !arb.bot_empty;

    // Word to capture from the latched source, optionally source-tagged
    always_comb begin
        cap_word = src_bot_q ? arb.bot_dout : arb.udp_dout;
`ifdef ARB_TAG_FORCE_EN
        cap_word[14] = src_bot_q;
`endif
    end

    // Next-state and registered-output logic of the issue FSM
    always_comb begin
        state_d   = state_q;
        src_bot_d = src_bot_q;
        udp_rd_d  = 1'b0;
        bot_rd_d  = 1'b0;
        vld_d     = 1'b0;
        data_d    = data_q;
        obot_d    = obot_q;
        ucnt_d    = ucnt_q;
        bcnt_d    = bcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (run_q && !arb.engine_busy && any_req) begin
                    src_bot_d = arb.udp_empty;
                    udp_rd_d  = !arb.udp_empty;
                    bot_rd_d  = arb.udp_empty;
                    state_d   = S_RD;
                end
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                data_d = cap_word;
                obot_d = src_bot_q;
                vld_d  = 1'b1;
                if (src_bot_q) begin
                    if (bcnt_q != '1)
                        bcnt_d = bcnt_q + CNT_W'(1);
                end else begin
                    if (ucnt_q != '1)
                        ucnt_d = ucnt_q + CNT_W'(1);
                end
                state_d = S_HOLD;
            end
            S_HOLD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; run_q holds off the first pop one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            run_q     <= 1'b0;
            src_bot_q <= 1'b0;
            udp_rd_q  <= 1'b0;
            bot_rd_q  <= 1'b0;
            vld_q     <= 1'b0;
            data_q    <= '0;
            obot_q    <= 1'b0;
            ucnt_q    <= '0;
            bcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            src_bot_q <= src_bot_d;
            udp_rd_q  <= udp_rd_d;
            bot_rd_q  <= bot_rd_d;
            vld_q     <= vld_d;
            data_q    <= data_d;
            obot_q    <= obot_d;
            ucnt_q    <= ucnt_d;
            bcnt_q    <= bcnt_d;
        end
    end

    assign arb.udp_rd_en         = udp_rd_q;
    assign arb.bot_rd_en         = bot_rd_q;
    assign arb.ord_valid         = vld_q;
    assign arb.ord_data          = data_q;
    assign arb.ord_src_bot       = obot_q;
    assign arb.udp_fifo_has_data = !arb.udp_empty;
    assign arb.udp_cnt           = ucnt_q;
    assign arb.bot_cnt           = bcnt_q;
endmodule

// File: tb/tb_order_ingress_arbiter.sv
// Bench for order_ingress_arbiter: vector table, FIFO model,
// expected-order scoreboard and multi-cycle corner sequences.
module tb_order_ingress_arbiter;
    logic clk;
    logic rst_n;

    order_ingress_arbiter_if #(.CNT_W(16)) bif ();
    order_ingress_arbiter_if #(.CNT_W(2))  sif ();

    order_ingress_arbiter #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (bif)
    );

    order_ingress_arbiter #(.CNT_W(2)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        bot;
    } exp_t;

    typedef struct {
        logic        has_u;
        logic        has_b;
        logic [31:0] uw;
        logic [31:0] bw;
        int          busy;
        int          n_exp;
        int          lat;
        int          gap;
    } vec_t;

    int          tests;
    int          fails;
    int          exp_ucnt;
    int          exp_bcnt;
    exp_t        exp_q[$];
    logic [31:0] udp_fq[$];
    logic [31:0] bot_fq[$];
    vec_t        vt[5];

    function automatic logic [31:0] exp_word(logic [31:0] w, logic bot);
        logic [31:0] r;
        r = w;
`ifdef ARB_TAG_FORCE_EN
        r[14] = bot;
`endif
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic push_udp(logic [31:0] w);
        exp_t e;
        udp_fq.push_back(w);
        bif.udp_empty = 1'b0;
        e.data = exp_word(w, 1'b0);
        e.bot  = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_bot(logic [31:0] w);
        exp_t e;
        bot_fq.push_back(w);
        bif.bot_empty = 1'b0;
        e.data = exp_word(w, 1'b1);
        e.bot  = 1'b1;
        exp_q.push_back(e);
    endtask

    // One cycle: FIFO model, then scoreboard on the issue port
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (bif.udp_rd_en || bif.bot_rd_en)
            chk("rd_excl", 32'(bif.udp_rd_en && bif.bot_rd_en), 0);
        if (bif.udp_rd_en && udp_fq.size() > 0)
            bif.udp_dout = udp_fq.pop_front();
        if (bif.bot_rd_en && bot_fq.size() > 0)
            bif.bot_dout = bot_fq.pop_front();
        if (bif.ord_valid) begin
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid: got data %h expected none",
                         bif.ord_data);
            end else begin
                e = exp_q.pop_front();
                if (e.bot) exp_bcnt++;
                else       exp_ucnt++;
                chk("ord_data", bif.ord_data, e.data);
                chk("ord_src_bot", 32'(bif.ord_src_bot), 32'(e.bot));
                chk("udp_cnt", 32'(bif.udp_cnt), exp_ucnt);
                chk("bot_cnt", 32'(bif.bot_cnt), exp_bcnt);
            end
        end
        bif.udp_empty = (udp_fq.size() == 0);
        bif.bot_empty = (bot_fq.size() == 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() > 0; i++)
            tick();
        chk("drain", exp_q.size(), 0);
        tick();
        tick();
    endtask

    task automatic chk_zero(string nm);
        chk({nm, "_udp_rd"}, 32'(bif.udp_rd_en), 0);
        chk({nm, "_bot_rd"}, 32'(bif.bot_rd_en), 0);
        chk({nm, "_valid"}, 32'(bif.ord_valid), 0);
        chk({nm, "_data"}, bif.ord_data, 0);
        chk({nm, "_src"}, 32'(bif.ord_src_bot), 0);
        chk({nm, "_ucnt"}, 32'(bif.udp_cnt), 0);
        chk({nm, "_bcnt"}, 32'(bif.bot_cnt), 0);
    endtask

    initial begin
        int n;
        int nseen;
        int t_first;
        int t_last;
        int gap;
        logic quiet;

        tests    = 0;
        fails    = 0;
        exp_ucnt = 0;
        exp_bcnt = 0;

        vt[0] = '{1'b1, 1'b0, 32'h0064_800A, 32'h0,
                  0, 1, 3, 0};
        vt[1] = '{1'b1, 1'b1, 32'h0064_800A, 32'h0065_C00A,
                  0, 2, 3, 4};
        vt[2] = '{1'b0, 1'b1, 32'h0, 32'h0063_000A,
                  0, 1, 3, 0};
        vt[3] = '{1'b1, 1'b0, 32'h0064_400A, 32'h0,
                  20, 1, 3, 0};
        vt[4] = '{1'b1, 1'b1, 32'h0064_400A, 32'h0063_000A,
                  0, 2, 3, 4};

        rst_n           = 1'b0;
        bif.udp_empty   = 1'b1;
        bif.bot_empty   = 1'b1;
        bif.udp_dout    = '0;
        bif.bot_dout    = '0;
        bif.engine_busy = 1'b0;
        sif.udp_empty   = 1'b0;
        sif.bot_empty   = 1'b1;
        sif.udp_dout    = 32'h0001_0001;
        sif.bot_dout    = '0;
        sif.engine_busy = 1'b1;

        push_udp(32'h0000_8001);
        tick();
        tick();
        chk_zero("reset");

        rst_n = 1'b1;
        tick();
        chk("first_pop_hold", 32'(bif.udp_rd_en), 0);
        drain();

        foreach (vt[v]) begin
            if (vt[v].busy > 0) bif.engine_busy = 1'b1;
            if (vt[v].has_u) push_udp(vt[v].uw);
            if (vt[v].has_b) push_bot(vt[v].bw);
            quiet = 1'b1;
            for (int b = 0; b < vt[v].busy; b++) begin
                tick();
                if (bif.udp_rd_en || bif.bot_rd_en || bif.ord_valid)
                    quiet = 1'b0;
            end
            if (vt[v].busy > 0) chk("busy_quiet", 32'(quiet), 1);
            bif.engine_busy = 1'b0;
            n       = 0;
            nseen   = 0;
            t_first = -1;
            t_last  = -1;
            gap     = -1;
            for (int k = 0; k < 40; k++) begin
                tick();
                n++;
                if (bif.ord_valid) begin
                    if (nseen == 0) t_first = n;
                    else            gap = n - t_last;
                    t_last = n;
                    nseen++;
                end
                if (nseen == vt[v].n_exp) break;
            end
            chk($sformatf("v%0d_count", v), nseen, vt[v].n_exp);
            chk($sformatf("v%0d_latency", v), t_first, vt[v].lat);
            if (vt[v].n_exp > 1)
                chk($sformatf("v%0d_gap", v), gap, vt[v].gap);
            drain();
        end

        push_udp(32'h0070_8005);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bif.udp_rd_en) break;
        end
        chk("inflight_rd", 32'(bif.udp_rd_en), 1);
        bif.engine_busy = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            n++;
            if (bif.ord_valid) break;
        end
        chk("inflight_busy_lat", n, 2);
        bif.engine_busy = 1'b0;
        drain();

        push_udp(32'h0071_8006);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bif.udp_rd_en) break;
        end
        chk("midop_rd", 32'(bif.udp_rd_en), 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk_zero("midop");
        exp_q.delete();
        exp_ucnt = 0;
        exp_bcnt = 0;
        tick();
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bif.ord_valid) quiet = 1'b0;
        end
        chk("midop_no_issue", 32'(quiet), 1);
        chk("midop_ucnt", 32'(bif.udp_cnt), 0);

        sif.engine_busy = 1'b0;
        n = 0;
        for (int c = 0; c < 60 && n < 5; c++) begin
            tick();
            if (sif.ord_valid) begin
                n++;
                chk("sat_cnt", 32'(sif.udp_cnt), (n > 3) ? 3 : n);
            end
        end
        sif.engine_busy = 1'b1;
        chk("sat_orders", n, 5);
        tick();
        tick();
        tick();
        chk("sat_final", 32'(sif.udp_cnt), 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/order_ingress_arbiter.md
ORDER_INGRESS_ARBITER -- requirements
Module: order_ingress_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of per-source order counters.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port udp_empty  input  1  UDP order FIFO empty flag.
REQ-005 SHALL have port udp_dout  input  32  UDP FIFO read data, valid one cycle after udp_rd_en.
REQ-006 SHALL have port udp_rd_en  output  1  UDP FIFO pop strobe.
REQ-007 SHALL have port bot_empty  input  1  Bot order FIFO empty flag.
REQ-008 SHALL have port bot_dout  input  32  Bot FIFO read data, valid one cycle after bot_rd_en.
REQ-009 SHALL have port bot_rd_en  output  1  Bot FIFO pop strobe.
REQ-010 SHALL have port engine_busy  input  1  matching engine busy; no issue while high.
REQ-011 SHALL have port ord_valid  output  1  one-cycle order strobe to matching engine.
REQ-012 SHALL have port ord_data  output  32  order word {price[31:16], is_buy[15], is_bot[14], qty[13:0]}.
REQ-013 SHALL have port ord_src_bot  output  1  1 = ord_data came from Bot FIFO.
REQ-014 SHALL have port udp_fifo_has_data  output  1  combinational !udp_empty, yield signal for the bot.
REQ-015 SHALL have ports udp_cnt, bot_cnt  output  CNT_W  orders issued per source.

Function
REQ-016 SHALL implement states S_IDLE, S_RD, S_CAP, S_HOLD.
REQ-017 S_IDLE: if !engine_busy and either FIFO non-empty, SHALL latch source (UDP if !udp_empty, else Bot), assert that source's rd_en registered, go S_RD; else stay.
REQ-018 Both FIFOs non-empty in same cycle SHALL select UDP (strict priority; Bot starvation under continuous UDP traffic is accepted).
REQ-019 S_RD: rd_en high exactly this one cycle; go S_CAP; never both rd_en high together.
REQ-020 S_CAP: SHALL register selected dout into ord_data, set ord_src_bot, set ord_valid, increment selected counter, go S_HOLD.
REQ-021 S_HOLD: ord_valid high exactly this cycle; go S_IDLE; ord_valid low in all other states.
REQ-022 Latency: non-empty seen in S_IDLE at cycle T -> rd_en cycle T+1 -> ord_valid cycle T+3; minimum issue spacing 4 cycles.
REQ-023 engine_busy SHALL be sampled only in S_IDLE; busy rising during S_RD/S_CAP SHALL NOT abort an in-flight pop.
REQ-024 ord_data and ord_src_bot SHALL hold last issued value until next S_CAP.
REQ-025 Counters SHALL saturate at all-ones, no wrap.
REQ-026 Empty flag deasserting after source latched SHALL not change the selected source.

Reset
REQ-027 rst_n low SHALL asynchronously force S_IDLE, udp_rd_en=0, bot_rd_en=0, ord_valid=0, ord_data=0, ord_src_bot=0, udp_cnt=0, bot_cnt=0.
REQ-028 Reset during S_RD/S_CAP SHALL discard the popped word without issuing it.
REQ-029 First pop after rst_n release SHALL occur no earlier than the second rising edge after release.

Configuration
REQ-030 Macro ARB_TAG_FORCE_EN defined: ord_data[14] SHALL be forced to 1 for Bot-sourced and 0 for UDP-sourced orders (anti-spoof).
REQ-031 ARB_TAG_FORCE_EN undefined: ord_data SHALL equal FIFO word unmodified; all else identical.

Verification
REQ-032 UDP only: push 0x0064_800A, engine idle -> udp_rd_en 1 cycle, ord_valid at T+3 with 0x0064800A, ord_src_bot=0, udp_cnt=1.
REQ-033 Simultaneous: UDP 0x0064_800A and Bot 0x0065_C00A both present -> UDP issued first, Bot issued 4 cycles later, ord_src_bot=1 on second.
REQ-034 Backpressure: engine_busy held high 20 cycles with UDP non-empty -> no rd_en, no ord_valid; first ord_valid 3 cycles after busy falls.
REQ-035 Tag force (macro defined): UDP word 0x0064_400A -> ord_data 0x0064_000A; Bot word 0x0063_000A -> 0x0063_400A; macro undefined -> both unmodified.
REQ-036 Reset mid-op: rst_n low during S_CAP -> all outputs zero immediately, counters 0, no ord_valid for popped word.
REQ-037 Saturation: CNT_W=2, issue 5 UDP orders -> udp_cnt stays 3.
